md_unit: RTL
============

# md_unit

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It consumes the already-forwarded E-stage rs/rt operands (post-FRSE/FRTE muxes) together with IR_E. It performs mult/multu/div/divu over a fixed multi-cycle latency, holds the architectural HI/LO registers, and serves mfhi/mflo/mthi/mtlo. It exports start/busy so the stall unit can freeze D-stage md-class instructions.

## Interface
- MULT_LAT, 5, cycles busy after a mult/multu start
- DIV_LAT, 10, cycles busy after a div/divu start
- clk  in  1  pipeline clock
- reset  in  1  one clock; reset is asynchronous and active-low
- IR_E  in  32  instruction in E stage
- A  in  32  forwarded rs value
- B  in  32  forwarded rt value
- start  out  1  combinational: IR_E is mult/multu/div/divu and busy==0
- busy  out  1  operation in flight
- md_out  out  32  mfhi ? HI : LO, combinational from current HI/LO
- HI  out  32  architectural HI
- LO  out  32  architectural LO

## Operation
- Decode on IR_E[31:26]==0 and funct: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mflo 010010, mthi 010001, mtlo 010011.
- Reset (reset==0, asynchronous): HI=LO=0, cnt=0, busy=0, pending result=0.
- States: IDLE (cnt==0) and RUN (cnt!=0); busy = (cnt!=0).
- IDLE + start: latch the result into res_hi/res_lo. Load cnt with MULT_LAT or DIV_LAT. Enter RUN.
- RUN: cnt decrements every edge. On the edge where cnt goes 1->0, HI<=res_hi and LO<=res_lo. Return to IDLE.
- mult: {HI,LO} = signed A*B (64-bit). multu: unsigned.
- div: LO = A/B truncated toward zero; HI = remainder with the sign of A. divu: unsigned.
- div/divu with B==0: timing is normal (busy DIV_LAT cycles); HI/LO unchanged at completion.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo: write A into HI/LO on the clock edge, only when busy==0. If busy, ignored.
- Boundary rules:
  - md-class instruction in E while busy: ignored; start stays 0. This is an assertion-fail condition, because the stall unit must prevent it.
  - mthi/mtlo on the completion edge: the completion write wins.
  - mfhi/mflo while busy return the stale HI/LO; the stall unit prevents this.
- Reset mid-RUN: the operation is discarded; HI/LO return to 0.

## Timing
- Start edge E0 (start=1 sampled): busy=1 during the next N cycles (N=MULT_LAT or DIV_LAT).
- HI/LO hold the new value from the edge E0+N; busy=0 in the same cycle.
- Back-to-back: a new start is accepted in the first cycle after busy falls.
- md_out has zero-cycle latency from HI/LO and IR_E.
- The stall unit stalls a D-stage md-class instruction while (start|busy).

## Structure
- Shared package: opcode/funct constants (SPECIAL, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO) and the default latency constants.
- One sub-module, md_calc: purely combinational 64-bit product/quotient/remainder from (op, A, B), including divide-by-zero and overflow cases. md_unit keeps the counter, result latches and HI/LO.

## Test plan
- Reset then idle: HI=LO=0, busy=0, md_out=0; assert reset mid-div -> busy=0 next cycle, HI/LO=0.
- mult A=0xFFFFFFFE(-2), B=3:
  - busy high for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=-7, B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 -> LO=3, HI=1.
- Preload HI=0x11, LO=0x22 via mthi/mtlo:
  - div by B=0 -> busy 10 cycles, HI/LO stay 0x11/0x22.
  - 0x80000000/-1 -> LO=0x80000000, HI=0.
- mthi issued while busy -> HI unchanged; mthi 0x55 on the first cycle after busy falls -> HI=0x55.
- mult, then mflo IR_E on the first non-busy cycle -> md_out equals the new LO. A second mult presented while busy -> start=0, result unaffected.

Source files
------------

// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - opcode/funct constants, op decode and default latencies for md_unit
package md_unit_pkg;

    localparam logic [5:0] SPECIAL = 6'b000000;
    localparam logic [5:0] MULT    = 6'b011000;
    localparam logic [5:0] MULTU   = 6'b011001;
    localparam logic [5:0] DIV     = 6'b011010;
    localparam logic [5:0] DIVU    = 6'b011011;
    localparam logic [5:0] MFHI    = 6'b010000;
    localparam logic [5:0] MFLO    = 6'b010010;
    localparam logic [5:0] MTHI    = 6'b010001;
    localparam logic [5:0] MTLO    = 6'b010011;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU,
        OP_MFHI,
        OP_MFLO,
        OP_MTHI,
        OP_MTLO
    } md_op_t;

    function automatic md_op_t md_decode(input logic [5:0] opcode, input logic [5:0] funct);
        md_op_t op;
        op = OP_NONE;
        if (opcode == SPECIAL) begin
            case (funct)
                MULT:    op = OP_MULT;
                MULTU:   op = OP_MULTU;
                DIV:     op = OP_DIV;
                DIVU:    op = OP_DIVU;
                MFHI:    op = OP_MFHI;
                MFLO:    op = OP_MFLO;
                MTHI:    op = OP_MTHI;
                MTLO:    op = OP_MTLO;
                default: op = OP_NONE;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - E-stage operand/result bundle between pipeline and md_unit
interface md_unit_if;
    logic [31:0] IR_E;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] md_out;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output IR_E, A, B, input start, busy, md_out, HI, LO);
    modport slave  (input IR_E, A, B, output start, busy, md_out, HI, LO);
endinterface

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational 64-bit product / quotient / remainder for md_unit
module md_calc
    import md_unit_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        wr
);

    logic               div_ovf;
    logic [31:0]        b_sdiv;
    logic [31:0]        b_udiv;
    logic signed [63:0] sprod;
    logic [63:0]        uprod;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic [31:0]        uq;
    logic [31:0]        ur;

    // Dividing by 1 instead of -1 yields exactly the required 0x80000000 r 0.
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign b_sdiv  = ((b == 32'd0) || div_ovf) ? 32'd1 : b;
    assign b_udiv  = (b == 32'd0) ? 32'd1 : b;

    assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uprod = {32'd0, a} * {32'd0, b};
    assign sq    = $signed(a) / $signed(b_sdiv);
    assign sr    = $signed(a) % $signed(b_sdiv);
    assign uq    = a / b_udiv;
    assign ur    = a % b_udiv;

    always_comb begin
        hi = 32'd0;
        lo = 32'd0;
        wr = 1'b0;
        case (op)
            OP_MULT:  begin {hi, lo} = sprod; wr = 1'b1;         end
            OP_MULTU: begin {hi, lo} = uprod; wr = 1'b1;         end
            OP_DIV:   begin hi = sr; lo = sq; wr = (b != 32'd0); end
            OP_DIVU:  begin hi = ur; lo = uq; wr = (b != 32'd0); end
            default:  ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle mult/div unit with architectural HI/LO for the E stage
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    md_op_t           op;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_wr;
    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;
    logic             calc_wr;
    logic             busy;
    logic             start;
    logic             is_mul;
    logic             is_div;
    logic             unused_ir_bits;

    assign op             = md_decode(bus.IR_E[31:26], bus.IR_E[5:0]);
    assign unused_ir_bits = ^bus.IR_E[25:6];

    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div = (op == OP_DIV)  || (op == OP_DIVU);
    assign busy   = (cnt != '0);
    assign start  = (is_mul || is_div) && !busy;

    md_calc u_calc (
        .op (op),
        .a  (bus.A),
        .b  (bus.B),
        .hi (calc_hi),
        .lo (calc_lo),
        .wr (calc_wr)
    );

    // HI/LO writes from mthi/mtlo are gated on !busy, so the completion write always wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            res_wr <= 1'b0;
        end else if (start) begin
            res_hi <= calc_hi;
            res_lo <= calc_lo;
            res_wr <= calc_wr;
            cnt    <= is_mul ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1) && res_wr) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end else begin
            if (op == OP_MTHI) hi_q <= bus.A;
            if (op == OP_MTLO) lo_q <= bus.A;
        end
    end

    assign bus.start  = start;
    assign bus.busy   = busy;
    assign bus.HI     = hi_q;
    assign bus.LO     = lo_q;
    assign bus.md_out = (op == OP_MFHI) ? hi_q : lo_q;

endmodule
